sudoku_board_dp: RTL and testbench
==================================

// Module: sudoku_board_dp
// PURPOSE
//  Datapath responder for the game-control FSM. Consumes the one-hot command flags
//  (gen_rand/set_board/set_diff/cell/val/check) and owns the N x N board, the solution
//  pattern and the givens mask. Returns `solved` to the controller, plus status to the user.
//  Single clock; all flag inputs are edge-detected, so multi-cycle flag levels act once.
// PARAMETERS
//  N         4        grid side (N = BOX*BOX); legal values 4 or 9
//  BOX       2        box side
//  IDXW      4        cell index width, >= clog2(N*N)
//  LFSR_SEED 16'hACE1 LFSR reset value; must be nonzero
// PORTS
//  clka           in   1     single system clock, rising edge
//  restart        in   1     asynchronous, active-high reset
//  gen_rand_flag  in   1     level: advance the LFSR every cycle while high
//  set_board_flag in   1     rise: latch rotation seed from LFSR
//  set_diff_flag  in   1     rise: latch difficulty, start FILL
//  cell_flag      in   1     rise: latch cell index from user_in[IDXW-1:0]
//  val_flag       in   1     rise: write user_in[3:0] to the latched cell
//  check_flag     in   1     rise: pulse check_done with current solved
//  user_in        in   8     user switches
//  solved         out  1     registered: match_cnt == N*N
//  busy           out  1     high during FILL
//  cell_err       out  1     latched cell is a given or index >= N*N
//  cur_val        out  4     board value at latched cell (0 = empty)
//  check_done     out  1     one-cycle pulse on check_flag rise
// BEHAVIOUR
//  Reset: all outputs 0; board, mask, seed, cell_idx, match_cnt = 0; diff = 0; LFSR = LFSR_SEED; state IDLE.
//  LFSR: 16-bit Fibonacci, taps 16,14,13,11; shifts when gen_rand_flag = 1 or state = FILL.
//  Edge detect: rise = flag & ~flag_q; flag_q is registered every cycle.
//  Solution (combinational): sol(r,c) = ((r*BOX + r/BOX + c + seed) mod N) + 1, with r = idx/N, c = idx%N.
//  set_board rise: seed <= lfsr[3:0] mod N.
//  FSM states IDLE -> FILL -> READY.
//   IDLE : set_diff rise -> diff <= user_in[1:0]; fill_idx <= 0; match_cnt <= 0; go to FILL.
//   FILL : one cell per cycle. given = (lfsr[2:0] < thr) with thr = {6,4,2,1}[diff].
//          mask[i] <= given; board[i] <= given ? sol(i) : 0; match_cnt += given.
//          fill_idx == N*N-1 -> READY. Duration is exactly N*N cycles. busy = 1.
//   READY: cell/val/check active. A set_diff rise re-enters FILL (new game).
//  cell/val rises in IDLE or FILL are ignored; check rise is honoured in any state.
//  cell rise: cell_idx <= user_in[IDXW-1:0]; cell_err <= mask[idx] | (idx >= N*N), computed next cycle.
//  val rise: write occurs only if ~cell_err and 1 <= v <= N; else board unchanged, cell_err <= 1.
//   Count update: old = board[idx].
//    match_cnt <= match_cnt - (old == sol) + (v == sol).
//    Rewriting the same value leaves the count unchanged.
//  solved: registered 1 cycle after the match_cnt update, i.e. valid 2 clka after the val rise.
//   The controller must not sample solved earlier.
//  check rise: check_done = 1 for 1 cycle, and solved is stable at that time.
//   If a check rise and a val rise occur in the same cycle, the write is applied first.
//  cur_val = board[cell_idx], registered.
//  restart asserted mid-FILL aborts the fill immediately and returns all state to reset values.
// TESTING
//  1. Reset, then hold gen_rand 5 cycles, then set_board rise -> seed == lfsr[3:0] % 4.
//     All outputs are 0 before the first flag.
//  2. seed=0, diff=0, set_diff rise -> busy high exactly 16 cycles.
//     Every given cell equals sol; match_cnt == popcount(mask).
//  3. Fill all empty cells with sol values via cell/val pairs -> solved = 1, 2 cycles after the last val rise.
//     A check rise then gives check_done = 1 and solved = 1.
//  4. Write a wrong value (sol = 3, write 2) into a solved board -> solved drops to 0.
//     Rewrite 3 -> solved returns to 1.
//  5. cell idx = given cell, or idx = 17 -> cell_err = 1.
//     A following val rise leaves the board unchanged. Writing v = 0 or v = 5 is also rejected.
//  6. restart asserted at fill cycle 7 -> busy = 0, board all 0, LFSR = 16'hACE1 on the next edge.

Source files
------------

// File: rtl/sudoku_board_dp.sv
// sudoku_board_dp -- datapath responder for the sudoku game-control FSM.
//
// Owns the N x N board, the givens mask and the rotation seed of the solution
// pattern. All command flags except gen_rand are rising-edge detected, so a
// flag held high for several cycles acts only once.
//
// Ports
//   clka           in  1    system clock, rising edge
//   restart        in  1    asynchronous active-high reset
//   gen_rand_flag  in  1    level: advance the LFSR every cycle while high
//   set_board_flag in  1    rise: latch rotation seed from the LFSR
//   set_diff_flag  in  1    rise: latch difficulty and start a new FILL
//   cell_flag      in  1    rise: latch cell index from user_in[IDXW-1:0]
//   val_flag       in  1    rise: write user_in[3:0] to the latched cell
//   check_flag     in  1    rise: pulse check_done
//   user_in        in  8    user switches
//   solved         out 1    every cell holds its solution value
//   busy           out 1    high while the board is being filled
//   cell_err       out 1    latched cell is a given, out of range, or last write rejected
//   cur_val        out 4    board value at the latched cell (0 = empty)
//   check_done     out 1    one-cycle pulse answering a check request
module sudoku_board_dp #(
  parameter int          N         = 4,
  parameter int          BOX       = 2,
  parameter int          IDXW      = 4,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic       clka,
  input  logic       restart,
  input  logic       gen_rand_flag,
  input  logic       set_board_flag,
  input  logic       set_diff_flag,
  input  logic       cell_flag,
  input  logic       val_flag,
  input  logic       check_flag,
  input  logic [7:0] user_in,
  output logic       solved,
  output logic       busy,
  output logic       cell_err,
  output logic [3:0] cur_val,
  output logic       check_done
);

  localparam int NC = N * N;
  localparam int FW = $clog2(NC);
  localparam int CW = $clog2(NC + 1);

  // positions of the edge-detected flags inside w_flags
  localparam int F_BOARD = 0;
  localparam int F_DIFF  = 1;
  localparam int F_CELL  = 2;
  localparam int F_VAL   = 3;
  localparam int F_CHECK = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_READY = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [15:0]     r_lfsr;
  logic [3:0]      r_seed;
  logic [1:0]      r_diff;
  logic [FW-1:0]   r_fill_idx;
  logic [CW-1:0]   r_match_cnt;
  logic [3:0]      r_board [NC];
  logic [NC-1:0]   r_mask;
  logic [IDXW-1:0] r_cell_idx;
  logic            r_cell_pend;
  logic            r_cell_err;
  logic [3:0]      r_cur_val;
  logic            r_solved;
  logic            r_busy;
  logic            r_chk_d1;
  logic            r_check_done;
  logic [4:0]      r_flag_q;

  logic [4:0]      w_flags;
  logic [4:0]      w_rise;
  logic            w_lfsr_fb;
  logic [2:0]      w_thr;
  logic            w_given;
  logic [3:0]      w_fill_sol;
  logic            w_idx_oob;
  logic [FW-1:0]   w_idx;
  logic [3:0]      w_v;
  logic            w_v_ok;
  logic [3:0]      w_old;
  logic [3:0]      w_sol;
  logic            w_cell_bad;
  logic            w_wr_ok;
  logic [CW-1:0]   w_cnt_dec;
  logic [CW-1:0]   w_cnt_inc;
  logic            w_unused;

  // Rotated Latin pattern: row r is shifted by r*BOX + r/BOX, which keeps
  // rows, columns and boxes free of repeats for any seed.
  function automatic logic [3:0] sol_f(input logic [FW-1:0] idx, input logic [3:0] seed);
    int r;
    int c;
    r = int'(idx) / N;
    c = int'(idx) % N;
    return 4'(((r * BOX + r / BOX + c + int'(seed)) % N) + 1);
  endfunction

  assign w_flags    = {check_flag, val_flag, cell_flag, set_diff_flag, set_board_flag};
  assign w_rise     = w_flags & ~r_flag_q;
  assign w_lfsr_fb  = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
  assign w_given    = (r_lfsr[2:0] < w_thr);
  assign w_fill_sol = sol_f(r_fill_idx, r_seed);
  // out-of-range indices are redirected to cell 0 so no array read goes past the end
  assign w_idx_oob  = (int'(r_cell_idx) >= NC);
  assign w_idx      = w_idx_oob ? '0 : FW'(r_cell_idx);
  assign w_v        = user_in[3:0];
  assign w_v_ok     = (w_v != 4'd0) && (int'(w_v) <= N);
  assign w_old      = r_board[w_idx];
  assign w_sol      = sol_f(w_idx, r_seed);
  assign w_cell_bad = w_idx_oob | r_mask[w_idx];
  assign w_wr_ok    = ~w_cell_bad & w_v_ok;
  assign w_cnt_dec  = CW'(w_old == w_sol);
  assign w_cnt_inc  = CW'(w_v == w_sol);
  assign w_unused   = ^user_in;

  // Difficulty to givens threshold: a cell is given when lfsr[2:0] < threshold.
  always_comb begin
    w_thr = 3'd6;
    case (r_diff)
      2'd0:    w_thr = 3'd6;
      2'd1:    w_thr = 3'd4;
      2'd2:    w_thr = 3'd2;
      2'd3:    w_thr = 3'd1;
      default: w_thr = 3'd6;
    endcase
  end

  // Game FSM next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_rise[F_DIFF]) w_state_nxt = S_FILL;
        else                w_state_nxt = S_IDLE;
      end
      S_FILL: begin
        if (r_fill_idx == FW'(NC - 1)) w_state_nxt = S_READY;
        else                           w_state_nxt = S_FILL;
      end
      S_READY: begin
        if (w_rise[F_DIFF]) w_state_nxt = S_FILL;
        else                w_state_nxt = S_READY;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register, LFSR, board storage, counters and registered outputs.
  always_ff @(posedge clka or posedge restart) begin
    if (restart) begin
      r_state      <= S_IDLE;
      r_lfsr       <= LFSR_SEED;
      r_seed       <= 4'd0;
      r_diff       <= 2'd0;
      r_fill_idx   <= '0;
      r_match_cnt  <= '0;
      r_mask       <= '0;
      r_cell_idx   <= '0;
      r_cell_pend  <= 1'b0;
      r_cell_err   <= 1'b0;
      r_cur_val    <= 4'd0;
      r_solved     <= 1'b0;
      r_busy       <= 1'b0;
      r_chk_d1     <= 1'b0;
      r_check_done <= 1'b0;
      r_flag_q     <= 5'd0;
      for (int i = 0; i < NC; i++) r_board[i] <= 4'd0;
    end else begin
      r_flag_q    <= w_flags;
      r_state     <= w_state_nxt;
      r_busy      <= (w_state_nxt == S_FILL);
      r_cell_pend <= 1'b0;

      if (gen_rand_flag || (r_state == S_FILL)) r_lfsr <= {r_lfsr[14:0], w_lfsr_fb};

      if (w_rise[F_BOARD]) r_seed <= 4'(int'(r_lfsr[3:0]) % N);

      // error flag settles one cycle after the index is latched
      if (r_cell_pend) r_cell_err <= w_cell_bad;

      if (w_rise[F_DIFF] && (r_state != S_FILL)) begin
        r_diff      <= user_in[1:0];
        r_fill_idx  <= '0;
        r_match_cnt <= '0;
      end else if (r_state == S_FILL) begin
        r_mask[r_fill_idx]  <= w_given;
        r_board[r_fill_idx] <= w_given ? w_fill_sol : 4'd0;
        r_match_cnt         <= r_match_cnt + CW'(w_given);
        r_fill_idx          <= r_fill_idx + FW'(1);
      end else if (r_state == S_READY) begin
        if (w_rise[F_CELL]) begin
          r_cell_idx  <= user_in[IDXW-1:0];
          r_cell_pend <= 1'b1;
        end
        if (w_rise[F_VAL]) begin
          if (w_wr_ok) begin
            r_board[w_idx] <= w_v;
            r_match_cnt    <= r_match_cnt - w_cnt_dec + w_cnt_inc;
          end else begin
            r_cell_err <= 1'b1;
          end
        end
      end else begin
        r_fill_idx <= r_fill_idx;
      end

      r_cur_val <= w_idx_oob ? 4'd0 : r_board[w_idx];
      r_solved  <= (r_match_cnt == CW'(NC));
      // two-stage delay lines check_done up with solved after a same-cycle write
      r_chk_d1     <= w_rise[F_CHECK];
      r_check_done <= r_chk_d1;
    end
  end

  assign solved     = r_solved;
  assign busy       = r_busy;
  assign cell_err   = r_cell_err;
  assign cur_val    = r_cur_val;
  assign check_done = r_check_done;

endmodule

// File: tb/tb_sudoku_board_dp.sv
// Directed testbench for sudoku_board_dp (N=4, BOX=2, IDXW=5 so index 17 is representable).
module tb_sudoku_board_dp;

  logic       clka = 1'b0;
  logic       restart;
  logic       gen_rand_flag;
  logic       set_board_flag;
  logic       set_diff_flag;
  logic       cell_flag;
  logic       val_flag;
  logic       check_flag;
  logic [7:0] user_in;
  logic       solved;
  logic       busy;
  logic       cell_err;
  logic [3:0] cur_val;
  logic       check_done;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] m_lfsr;
  int          m_seed;
  bit          m_mask [16];
  int          row_off [4] = '{0, 2, 1, 3};
  int          n_empty;
  int          k_wr;
  int          w_cell;
  int          g_cell;
  int          wrong_v;
  int          busy_cnt;

  sudoku_board_dp #(.N(4), .BOX(2), .IDXW(5), .LFSR_SEED(16'hACE1)) dut (
    .clka(clka), .restart(restart), .gen_rand_flag(gen_rand_flag),
    .set_board_flag(set_board_flag), .set_diff_flag(set_diff_flag),
    .cell_flag(cell_flag), .val_flag(val_flag), .check_flag(check_flag),
    .user_in(user_in), .solved(solved), .busy(busy), .cell_err(cell_err),
    .cur_val(cur_val), .check_done(check_done)
  );

  always #5 clka = ~clka;

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  function automatic int sol_of(input int i);
    return ((row_off[i / 4] + (i % 4) + m_seed) % 4) + 1;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clka);
    #1;
  endtask

  task automatic sel_cell(input int i);
    user_in = 8'(i); cell_flag = 1'b1; tick();
    cell_flag = 1'b0; tick();
  endtask

  // returns at the sampling point right after the edge that saw the rise
  task automatic write_val(input int v);
    user_in = 8'(v); val_flag = 1'b1; tick();
    val_flag = 1'b0;
  endtask

  task automatic gen_and_seed();
    gen_rand_flag = 1'b1;
    repeat (5) begin tick(); m_lfsr = lfsr_next(m_lfsr); end
    gen_rand_flag = 1'b0; set_board_flag = 1'b1; tick();
    set_board_flag = 1'b0; tick();
    m_seed = int'(m_lfsr[3:0]) % 4;
  endtask

  task automatic start_fill(input int d, input int thr);
    for (int i = 0; i < 16; i++) begin
      m_mask[i] = (int'(m_lfsr[2:0]) < thr);
      m_lfsr = lfsr_next(m_lfsr);
    end
    user_in = 8'(d); set_diff_flag = 1'b1; tick();
    set_diff_flag = 1'b0;
    busy_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      if (busy === 1'b1) busy_cnt++;
      tick();
    end
    chk("busy_cycles", 16'(busy_cnt), 16'd16);
    chk("busy_after_fill", busy, 1'b0);
  endtask

  task automatic verify_board();
    for (int i = 0; i < 16; i++) begin
      sel_cell(i);
      chk($sformatf("cell%0d_val", i), cur_val, m_mask[i] ? 16'(sol_of(i)) : 16'd0);
      chk($sformatf("cell%0d_err", i), cell_err, 16'(m_mask[i]));
    end
  endtask

  task automatic check_pulse(input string tag, input logic exp_solved, input bit with_val, input int v);
    int k;
    if (with_val) begin user_in = 8'(v); val_flag = 1'b1; end
    check_flag = 1'b1; tick();
    check_flag = 1'b0; val_flag = 1'b0;
    for (k = 0; k < 4 && check_done !== 1'b1; k++) tick();
    chk({tag, "_done"}, check_done, 1'b1);
    chk({tag, "_solved"}, solved, exp_solved);
    tick();
    chk({tag, "_pulse_end"}, check_done, 1'b0);
  endtask

  initial begin
    restart = 1'b1; gen_rand_flag = 1'b0; set_board_flag = 1'b0; set_diff_flag = 1'b0;
    cell_flag = 1'b0; val_flag = 1'b0; check_flag = 1'b0; user_in = 8'd0;
    m_lfsr = 16'hACE1; m_seed = 0;
    repeat (2) tick();
    restart = 1'b0;
    tick();

    // reset state
    chk("rst_solved", solved, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_cell_err", cell_err, 1'b0);
    chk("rst_cur_val", cur_val, 4'd0);
    chk("rst_check_done", check_done, 1'b0);

    // seed from LFSR after 5 gen_rand cycles; a check in IDLE is still honoured
    gen_and_seed();
    chk("idle_busy", busy, 1'b0);
    check_pulse("idle_check", 1'b0, 1'b0, 0);

    // fill at difficulty 0, then read back every cell
    start_fill(0, 6);
    verify_board();
    chk("partial_not_solved", solved, 1'b0);

    // complete the board by hand
    n_empty = 0;
    for (int i = 0; i < 16; i++) if (!m_mask[i]) n_empty++;
    k_wr = 0;
    for (int i = 0; i < 16; i++) begin
      if (!m_mask[i]) begin
        sel_cell(i);
        write_val(sol_of(i));
        k_wr++;
        if (k_wr == n_empty) chk("solved_1clk", solved, 1'b0);
        tick();
        if (k_wr == n_empty) chk("solved_2clk", solved, 1'b1);
        chk($sformatf("wr%0d_cur_val", i), cur_val, 16'(sol_of(i)));
      end
    end
    check_pulse("chk_solved", 1'b1, 1'b0, 0);

    // choose an empty cell (sol 3 if one exists) and a given cell
    w_cell = -1; g_cell = -1;
    for (int i = 0; i < 16; i++) if (!m_mask[i] && sol_of(i) == 3) w_cell = i;
    for (int i = 0; i < 16; i++) if (!m_mask[i] && w_cell < 0) w_cell = i;
    for (int i = 0; i < 16; i++) if (m_mask[i] && g_cell < 0) g_cell = i;
    if (w_cell < 0) w_cell = 0;
    if (g_cell < 0) g_cell = 0;
    wrong_v = (sol_of(w_cell) == 3) ? 2 : (sol_of(w_cell) % 4) + 1;

    // wrong value drops solved, rewriting the solution restores it
    sel_cell(w_cell);
    write_val(wrong_v); tick();
    chk("wrong_solved", solved, 1'b0);
    chk("wrong_cur_val", cur_val, 16'(wrong_v));
    write_val(sol_of(w_cell)); tick();
    chk("fix_solved", solved, 1'b1);
    write_val(sol_of(w_cell)); tick();
    chk("rewrite_same_solved", solved, 1'b1);

    // check and val in the same cycle: check sees the write
    check_pulse("chk_with_wr", 1'b0, 1'b1, wrong_v);
    write_val(sol_of(w_cell)); tick();
    chk("restore_solved", solved, 1'b1);

    // writes to a given cell are rejected
    sel_cell(g_cell);
    chk("given_err", cell_err, 1'b1);
    write_val((sol_of(g_cell) % 4) + 1); tick();
    chk("given_unchanged", cur_val, 16'(sol_of(g_cell)));
    chk("given_solved", solved, 1'b1);

    // out-of-range index
    sel_cell(17);
    chk("oob_err", cell_err, 1'b1);
    chk("oob_cur_val", cur_val, 4'd0);
    write_val(1); tick();
    chk("oob_solved", solved, 1'b1);

    // values 0 and 5 are rejected on an editable cell
    sel_cell(w_cell);
    chk("edit_err_clear", cell_err, 1'b0);
    write_val(0); tick();
    chk("v0_unchanged", cur_val, 16'(sol_of(w_cell)));
    chk("v0_err", cell_err, 1'b1);
    write_val(5); tick();
    chk("v5_unchanged", cur_val, 16'(sol_of(w_cell)));
    chk("v5_err", cell_err, 1'b1);
    chk("v5_solved", solved, 1'b1);

    // restart in the middle of a new fill
    user_in = 8'd0; set_diff_flag = 1'b1; tick();
    set_diff_flag = 1'b0;
    chk("refill_busy", busy, 1'b1);
    repeat (6) tick();
    restart = 1'b1;
    #1;
    chk("abort_busy_async", busy, 1'b0);
    tick();
    chk("abort_busy", busy, 1'b0);
    chk("abort_solved", solved, 1'b0);
    chk("abort_cell_err", cell_err, 1'b0);
    chk("abort_cur_val", cur_val, 4'd0);
    chk("abort_check_done", check_done, 1'b0);
    restart = 1'b0;
    tick();
    chk("post_rst_cur_val", cur_val, 4'd0);

    // LFSR is back at its seed: same gen_rand sequence, new game at difficulty 1
    m_lfsr = 16'hACE1;
    gen_and_seed();
    start_fill(1, 4);
    verify_board();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
